// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state encoding and slice width for the nibble-serial adder
package nibble_serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/nibble_add4.sv
// nibble_add4: combinational 4-bit adder slice
module nibble_add4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);
  assign {co, s} = a + b + {{NIBBLE_W{1'b0}}, ci};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide adder reusing one 4-bit slice, one nibble per clock, LSB first
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  nsa_state_t st, nst;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] ra, rb;
  logic c, co, last;
  logic [NIBBLE_W-1:0] na, nb, s;
  assign na = NIBBLE_W'(ra >> (idx * NIBBLE_W));
  assign nb = NIBBLE_W'(rb >> (idx * NIBBLE_W));
  assign last = idx == IW'(NIB - 1);
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
  nibble_add4 u_add (.a(na), .b(nb), .ci(c), .s(s), .co(co));
  always_comb begin
    nst = st;
    nst = st == IDLE ? (in_valid ? RUN : IDLE) :
          st == RUN  ? (last ? DONE : RUN) :
                       (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nst;
  // sum is cleared on accept so each nibble can simply be OR-ed into place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0;
      rb <= '0;
      c <= 1'b0;
      idx <= '0;
      sum <= '0;
      cout <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (st == IDLE && in_valid) begin
      ra <= a;
      rb <= b;
      c <= cin;
      idx <= '0;
      sum <= '0;
    end else if (st == RUN) begin
      sum <= sum | (WIDTH'(s) << (idx * NIBBLE_W));
      c <= co;
      idx <= last ? idx : idx + 1'b1;
      if (last) cout <= co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      if (last) ovf <= (ra[WIDTH-1] == rb[WIDTH-1]) && (s[NIBBLE_W-1] != ra[WIDTH-1]);
`endif
    end
  end
endmodule
